// File: rtl/pipe_adder.sv
// pipe_adder: WIDTH-bit add/subtract split into STAGES chunk adders, carry rippled through stage registers.
// Latency STAGES cycles, 1 op/cycle; stalls propagate backwards, bubbles collapse. Optional clamp: ADDER_SAT_EN.
module pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
`ifdef ADDER_SAT_EN
  ,
  input  logic             sat
`endif
);

  localparam int CW = WIDTH / STAGES;

  generate
    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
      $error("pipe_adder: WIDTH must be a non-zero multiple of STAGES");
    end
  endgenerate

  // a/b hold the effective operands; r fills in one chunk per stage.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] r;
    logic             c;
    logic             s;
    logic             ovf;
  } stage_t;

  stage_t            q   [STAGES];
  stage_t            src [STAGES];
  stage_t            nxt [STAGES];
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] vin;
  logic [STAGES-1:0] load;
  logic [CW:0]       sum;
  logic              take;

  always_comb begin
    src[0]   = '0;
    src[0].a = op_a;
    src[0].b = sub ? ~op_b : op_b;
    src[0].c = sub ^ cin;
`ifdef ADDER_SAT_EN
    src[0].s = sat;
`else
    src[0].s = 1'b0;
`endif
    for (int k = 1; k < STAGES; k++) begin
      src[k] = q[k-1];
    end
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < STAGES; k++) begin
      nxt[k] = src[k];
      sum = {1'b0, src[k].a[k*CW +: CW]} + {1'b0, src[k].b[k*CW +: CW]}
          + {{CW{1'b0}}, src[k].c};
      nxt[k].r[k*CW +: CW] = sum[CW-1:0];
      nxt[k].c             = sum[CW];
      if (k == STAGES-1) begin
        nxt[k].ovf = (src[k].a[WIDTH-1] == src[k].b[WIDTH-1]) &&
                     (sum[CW-1] != src[k].a[WIDTH-1]);
`ifdef ADDER_SAT_EN
        if (src[k].s && nxt[k].ovf) begin
          nxt[k].r = src[k].a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
      end
    end
  end

  // A stage may load if it or any stage downstream of it has room this cycle.
  always_comb begin
    take = out_ready;
    load = '0;
    for (int k = STAGES-1; k >= 0; k--) begin
      take    = take | ~v[k];
      load[k] = take;
    end
    vin    = '0;
    vin[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      vin[k] = v[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      for (int k = 0; k < STAGES; k++) begin
        q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          v[k] <= vin[k];
          if (vin[k]) begin
            q[k] <= nxt[k];
          end
        end
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = v[STAGES-1];
  assign result    = q[STAGES-1].r;
  assign cout      = q[STAGES-1].c;
  assign overflow  = q[STAGES-1].ovf;

endmodule
